board_seeder: RTL and testbench
===============================

# board_seeder

Random initial-population generator for the Game-of-Life board. It walks every cell in row-major order and issues one comparison per cell to the shared registered comparator: operand A is the density threshold and operand B is a 10-bit LFSR value. It reads the comparator result back one cycle later and writes that result into the board memory as the cell's initial alive bit. The block sits between the top-level control FSM (start/done) and the comparator plus board write port.

## Interface
Parameters:
- ROWS, 16, board rows (≥1)
- COLS, 16, board columns (≥1)
- SEED, 10'h001, LFSR reset value; 10'h000 is replaced by 10'h001

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to seed the board; ignored while busy=1
- density  in  10  alive threshold; sampled only on an accepted start
- cmp_a  out  10  comparator operand A (latched density)
- cmp_b  out  10  comparator operand B (current LFSR value)
- cmp_result  in  1  comparator registered output, (cmp_a > cmp_b) from the previous cycle
- wr_en  out  1  board write strobe
- wr_row  out  $clog2(ROWS)  write row address
- wr_col  out  $clog2(COLS)  write column address
- wr_data  out  1  cell alive bit (= cmp_result)
- busy  out  1  high from accepted start through DONE
- done  out  1  one-cycle completion pulse

## Operation
- This block has one clock and one reset. Reset is synchronous and active-high.
- States:
  - IDLE: waiting for a request.
  - RUN: issues one cell per cycle.
  - DRAIN: performs the write for the last cell.
  - DONE: raises done for one cycle.
- State transitions:
  - IDLE -> RUN on start. density is latched into density_q, and the issue counters (irow, icol) are cleared.
  - RUN: each cycle presents cmp_a = density_q and cmp_b = lfsr for cell (irow, icol). At the clock edge the LFSR advances, icol increments, and icol wraps from COLS-1 to 0 while irow increments.
  - RUN -> DRAIN after the cycle that issues cell (ROWS-1, COLS-1).
  - DRAIN -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- Write path:
  - Row and column addresses are delayed by one register stage (wrow, wcol), along with a valid flag (wvalid = issued last cycle).
  - wr_en = wvalid, wr_row = wrow, wr_col = wcol.
  - wr_data = cmp_result, combinational pass-through.
- LFSR: 10-bit Fibonacci, polynomial x^10 + x^7 + 1. Next value = {lfsr[8:0], lfsr[9] ^ lfsr[6]}. Period 1023; the value is never 0.
  - The LFSR advances only in RUN.
  - It is not reloaded between runs, so successive seedings differ.
  - Reset reloads SEED.
- Cell alive rule: alive iff density_q > LFSR value at issue (unsigned).
  - density 0 gives an all-dead board.
  - Density is a 10-bit quantity; no widening.
- cmp_a and cmp_b are driven continuously from density_q and lfsr in every state. Only RUN-cycle results are written.
- start arriving in RUN, DRAIN or DONE is dropped, not queued. A start in the same cycle as Reset is ignored.
- Reset mid-run: the next cycle is IDLE with wr_en = 0, busy = 0, done = 0. The partially written board is left as is; no further writes occur.

## Timing
- Reset values:
  - State IDLE, busy 0, done 0, wr_en 0.
  - wr_row 0, wr_col 0.
  - cmp_a 0 (density_q = 0), cmp_b = SEED (or 1 if SEED = 0).
- wr_data is undefined-but-unused while wr_en = 0.
- Latency: start is sampled at edge E0. Cell k is issued in cycle k+1 after E0 and written in cycle k+2.
- N = ROWS*COLS. Writes occupy N consecutive cycles with no gaps.
- Run length:
  - The last write occurs in DRAIN.
  - done is high in the cycle after DRAIN, i.e. N+2 cycles after E0.
  - busy is high from the cycle after E0 through the DONE cycle inclusive.
- A new start is accepted in the cycle after DONE, i.e. in IDLE.
- Throughput: one cell per clock.

## Test plan
- Reset: hold Reset for 2 cycles, then release. Required: busy = 0, done = 0, wr_en = 0, cmp_b = 10'h001 (SEED default). Repeat with SEED = 0: cmp_b = 10'h001.
- Small board, ROWS = 2, COLS = 3, SEED = 1: start with density = 5. Required:
  - The LFSR issues 1, 2, 4, 8, 16, 32.
  - Writes (0,0)..(1,2) carry data 1, 1, 1, 0, 0, 0 on consecutive cycles.
  - done is high exactly 8 cycles after start.
- Full 16x16 board, density = 0: required 256 writes, all wr_data = 0, row-major addresses with no gaps, and one done pulse.
- Full 16x16 board, density = 1023: each wr_data matches a bench LFSR model (1023 > value). A second start continues the LFSR sequence rather than restarting it.
- start pulsed while busy, at cycles 5 and 40: required no effect on the address sequence, the write count, or done timing. density changed mid-run has no effect.
- Reset asserted at cycle 100 of a 16x16 run: required wr_en = 0 and busy = 0 the next cycle, cmp_b = SEED, and no done pulse. A subsequent start performs a full, correct run.

Source files
------------

// File: rtl/board_seeder.sv
`timescale 1ns/1ps
// board_seeder: walks every board cell in row-major order, issues one
// (density > lfsr) comparison per cell to an external registered comparator
// and writes the returned bit into the board as the cell's initial state.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start, density  seed request and alive threshold (sampled on accepted start)
//   cmp_a, cmp_b    comparator operands: latched density, current LFSR value
//   cmp_result      comparator registered result from the previous cycle
//   wr_en, wr_row, wr_col, wr_data   board write port
//   busy, done      run in progress, one-cycle completion pulse
module board_seeder #(
    parameter int unsigned ROWS = 16,
    parameter int unsigned COLS = 16,
    parameter logic [9:0]  SEED = 10'h001
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [9:0]                                  density,
    output logic [9:0]                                  cmp_a,
    output logic [9:0]                                  cmp_b,
    input  logic                                        cmp_result,
    output logic                                        wr_en,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]  wr_row,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]  wr_col,
    output logic                                        wr_data,
    output logic                                        busy,
    output logic                                        done
);

    // Single-row / single-column boards still get a 1-bit address.
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    // The all-zero state would lock up the LFSR.
    localparam logic [9:0]  SEED_EFF = (SEED == 10'h000) ? 10'h001 : SEED;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q,   state_d;
    logic [9:0]      density_q, density_d;
    logic [9:0]      lfsr_q,    lfsr_d;
    logic [RW-1:0]   irow_q,    irow_d;
    logic [CW-1:0]   icol_q,    icol_d;
    logic            wvalid_q,  wvalid_d;
    logic [RW-1:0]   wrow_q,    wrow_d;
    logic [CW-1:0]   wcol_q,    wcol_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    logic            last_col_c;
    logic            last_cell_c;

    assign last_col_c  = (icol_q == LAST_COL);
    assign last_cell_c = last_col_c && (irow_q == LAST_ROW);

    // Next-state, issue counters, LFSR and the one-stage write pipeline.
    always_comb begin
        state_d   = state_q;
        density_d = density_q;
        lfsr_d    = lfsr_q;
        irow_d    = irow_q;
        icol_d    = icol_q;
        wvalid_d  = 1'b0;
        wrow_d    = wrow_q;
        wcol_d    = wcol_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    density_d = density;
                    irow_d    = '0;
                    icol_d    = '0;
                end
            end
            S_RUN: begin
                // x^10 + x^7 + 1 Fibonacci step; only advances while issuing.
                lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
                wvalid_d = 1'b1;
                wrow_d   = irow_q;
                wcol_d   = icol_q;
                if (last_cell_c) begin
                    state_d = S_DRAIN;
                    irow_d  = '0;
                    icol_d  = '0;
                end else if (last_col_c) begin
                    irow_d = irow_q + RW'(1);
                    icol_d = '0;
                end else begin
                    icol_d = icol_q + CW'(1);
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            density_q <= '0;
            lfsr_q    <= SEED_EFF;
            irow_q    <= '0;
            icol_q    <= '0;
            wvalid_q  <= 1'b0;
            wrow_q    <= '0;
            wcol_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            density_q <= density_d;
            lfsr_q    <= lfsr_d;
            irow_q    <= irow_d;
            icol_q    <= icol_d;
            wvalid_q  <= wvalid_d;
            wrow_q    <= wrow_d;
            wcol_q    <= wcol_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cmp_a   = density_q;
    assign cmp_b   = lfsr_q;
    assign wr_en   = wvalid_q;
    assign wr_row  = wrow_q;
    assign wr_col  = wcol_q;
    // Comparator is already registered, so its result lines up with wrow/wcol.
    assign wr_data = cmp_result;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_board_seeder.sv
`timescale 1ns/1ps
// tb_board_seeder: directed bench for board_seeder. Three instances share
// clk/rst: a 16x16 board (default SEED), a 2x3 board (SEED=1) and a 1x1 board
// (SEED=0). Each has its own registered comparator model.
module tb_board_seeder;

    localparam int N = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 16x16 instance
    logic       b_start, b_wen, b_wd, b_busy, b_done, b_res;
    logic [9:0] b_den, b_a, b_b;
    logic [3:0] b_row, b_col;
    // 2x3 instance
    logic       s_start, s_wen, s_wd, s_busy, s_done, s_res;
    logic [9:0] s_den, s_a, s_b;
    logic [0:0] s_row;
    logic [1:0] s_col;
    // 1x1 instance
    logic       o_start, o_wen, o_wd, o_busy, o_done, o_res;
    logic [9:0] o_den, o_a, o_b;
    logic [0:0] o_row, o_col;

    board_seeder #(.ROWS(16), .COLS(16)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .density(b_den),
        .cmp_a(b_a), .cmp_b(b_b), .cmp_result(b_res),
        .wr_en(b_wen), .wr_row(b_row), .wr_col(b_col), .wr_data(b_wd),
        .busy(b_busy), .done(b_done)
    );

    board_seeder #(.ROWS(2), .COLS(3), .SEED(10'h001)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .density(s_den),
        .cmp_a(s_a), .cmp_b(s_b), .cmp_result(s_res),
        .wr_en(s_wen), .wr_row(s_row), .wr_col(s_col), .wr_data(s_wd),
        .busy(s_busy), .done(s_done)
    );

    board_seeder #(.ROWS(1), .COLS(1), .SEED(10'h000)) u_one (
        .clk(clk), .rst(rst), .start(o_start), .density(o_den),
        .cmp_a(o_a), .cmp_b(o_b), .cmp_result(o_res),
        .wr_en(o_wen), .wr_row(o_row), .wr_col(o_col), .wr_data(o_wd),
        .busy(o_busy), .done(o_done)
    );

    // Shared registered comparator models.
    always @(posedge clk) begin
        b_res <= (b_a > b_b);
        s_res <= (s_a > s_b);
        o_res <= (o_a > o_b);
    end

    logic [9:0] lfsr_m;

    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Full 16x16 run with cycle-accurate checks against the bench LFSR model.
    task automatic run_big(input logic [9:0] den, input bit noisy);
        int  nwr;
        int  ndone;
        int  widx;
        bit  exp_wen;
        bit  exp_d;
        bit  q[$];
        nwr = 0; ndone = 0; widx = 0;
        b_start = 1'b1; b_den = den;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int cyc = 1; cyc <= N + 3; cyc++) begin
            exp_wen = (cyc >= 2) && (cyc <= N + 1);
            if (cyc <= N) begin
                chk("big_cmp_b", 32'(b_b), 32'(lfsr_m));
                q.push_back(den > lfsr_m);
                lfsr_m = lfsr_next(lfsr_m);
            end
            chk("big_cmp_a", 32'(b_a), 32'(den));
            chk("big_wr_en", 32'(b_wen), 32'(exp_wen));
            chk("big_busy", 32'(b_busy), 32'(cyc <= N + 2));
            chk("big_done", 32'(b_done), 32'(cyc == N + 2));
            if (exp_wen) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 1'b0;
                chk("big_wr_data", 32'(b_wd), 32'(exp_d));
                chk("big_wr_row", 32'(b_row), 32'(widx / 16));
                chk("big_wr_col", 32'(b_col), 32'(widx % 16));
                widx++;
            end
            if (b_wen) nwr++;
            if (b_done) ndone++;
            if (noisy) begin
                b_start = (cyc == 5) || (cyc == 40);
                if (cyc == 20) b_den = ~den;
            end
            @(posedge clk); #1;
        end
        b_start = 1'b0;
        b_den   = den;
        chk("big_write_count", 32'(nwr), 32'(N));
        chk("big_done_count", 32'(ndone), 32'd1);
    endtask

    typedef struct {
        logic       st;
        logic [9:0] den;
        logic [9:0] e_a;
        logic [9:0] e_b;
        logic       e_wen;
        logic [0:0] e_row;
        logic [1:0] e_col;
        logic       e_wd;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl[9];

    initial begin : main
        int nd;
        int nw;
        // inputs driven during cycle i; expectations for cycle i+1
        tbl[0] = '{1'b1, 10'd5,   10'd5, 10'd1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 10'd5,   10'd5, 10'd2,  1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 10'd900, 10'd5, 10'd4,  1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 10'd900, 10'd5, 10'd8,  1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 10'd5,   10'd5, 10'd16, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 10'd5,   10'd5, 10'd32, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 10'd5,   10'd5, 10'd64, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 10'd5,   10'd5, 10'd64, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 10'd5,   10'd5, 10'd64, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        b_start = 1'b1; b_den = 10'd7;   // start during reset must be ignored
        s_start = 1'b0; s_den = 10'd0;
        o_start = 1'b0; o_den = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; b_start = 1'b0;
        chk("rst_busy", 32'(b_busy), 32'd0);
        chk("rst_done", 32'(b_done), 32'd0);
        chk("rst_wr_en", 32'(b_wen), 32'd0);
        chk("rst_wr_row", 32'(b_row), 32'd0);
        chk("rst_wr_col", 32'(b_col), 32'd0);
        chk("rst_cmp_a", 32'(b_a), 32'd0);
        chk("rst_cmp_b", 32'(b_b), 32'h001);
        chk("rst_seed0_cmp_b", 32'(o_b), 32'h001);
        chk("rst_small_cmp_b", 32'(s_b), 32'h001);
        lfsr_m = 10'h001;

        // 2x3 board, density 5, table-driven
        for (int i = 0; i < 9; i++) begin
            s_start = tbl[i].st;
            s_den   = tbl[i].den;
            @(posedge clk); #1;
            chk($sformatf("small_cmp_a[%0d]", i), 32'(s_a), 32'(tbl[i].e_a));
            chk($sformatf("small_cmp_b[%0d]", i), 32'(s_b), 32'(tbl[i].e_b));
            chk($sformatf("small_wr_en[%0d]", i), 32'(s_wen), 32'(tbl[i].e_wen));
            chk($sformatf("small_busy[%0d]", i), 32'(s_busy), 32'(tbl[i].e_busy));
            chk($sformatf("small_done[%0d]", i), 32'(s_done), 32'(tbl[i].e_done));
            if (tbl[i].e_wen) begin
                chk($sformatf("small_wr_row[%0d]", i), 32'(s_row), 32'(tbl[i].e_row));
                chk($sformatf("small_wr_col[%0d]", i), 32'(s_col), 32'(tbl[i].e_col));
                chk($sformatf("small_wr_data[%0d]", i), 32'(s_wd), 32'(tbl[i].e_wd));
            end
        end
        s_start = 1'b0;

        // 1x1 board with SEED=0, density 2 (2 > 1 -> alive)
        o_start = 1'b1; o_den = 10'd2;
        @(posedge clk); #1;
        o_start = 1'b0;
        chk("one_c1_busy", 32'(o_busy), 32'd1);
        chk("one_c1_wr_en", 32'(o_wen), 32'd0);
        @(posedge clk); #1;
        chk("one_c2_wr_en", 32'(o_wen), 32'd1);
        chk("one_c2_wr_data", 32'(o_wd), 32'd1);
        chk("one_c2_addr", 32'({o_row, o_col}), 32'd0);
        chk("one_c2_done", 32'(o_done), 32'd0);
        @(posedge clk); #1;
        chk("one_c3_done", 32'(o_done), 32'd1);
        chk("one_c3_wr_en", 32'(o_wen), 32'd0);
        @(posedge clk); #1;
        chk("one_c4_busy", 32'(o_busy), 32'd0);
        chk("one_c4_cmp_b", 32'(o_b), 32'h002);

        // 16x16: density 0 with start pulses and density change mid-run
        run_big(10'd0, 1'b1);
        // density 1023 twice; the second run continues the LFSR sequence
        run_big(10'd1023, 1'b0);
        run_big(10'd1023, 1'b0);

        // reset at cycle 100 of a run
        b_start = 1'b1; b_den = 10'd512;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int cyc = 1; cyc < 100; cyc++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_wr_en", 32'(b_wen), 32'd0);
        chk("midrst_busy", 32'(b_busy), 32'd0);
        chk("midrst_done", 32'(b_done), 32'd0);
        chk("midrst_cmp_b", 32'(b_b), 32'h001);
        chk("midrst_cmp_a", 32'(b_a), 32'd0);
        nd = 0; nw = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            if (b_done) nd++;
            if (b_wen) nw++;
        end
        chk("midrst_no_done", 32'(nd), 32'd0);
        chk("midrst_no_writes", 32'(nw), 32'd0);
        lfsr_m = 10'h001;
        run_big(10'd300, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
